// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder: operation encoding, per-stage carry
// payload and the effective carry-in helper.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic carry;   // carry out of this stage's slice
        logic c_msb;   // carry into the top bit of this stage's slice
    } stage_pl_t;

    // SUB is a + ~b + ~borrow, so the borrow-in is inverted into a carry-in.
    function automatic logic eff_cin(op_e op, logic cin);
        return (op == OP_SUB) ? ~cin : cin;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple adder for one SLICE-bit chunk of the pipelined adder.
module adder_slice
    import adder_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[SLICE];
    assign c_top = c[SLICE-1];

endmodule

// File: rtl/pipe_adder.sv
// Valid/ready pipelined adder/subtractor: each stage adds one SLICE-bit chunk
// and forwards the remaining operand bits, the finished sum bits and the carry.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SLICE = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d, load;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    stage_pl_t         pl_q  [STAGES];
    stage_pl_t         pl_d  [STAGES];

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic              src_c   [STAGES];
    logic              src_v   [STAGES];
    logic [SLICE-1:0]  sl_sum  [STAGES];
    logic              sl_cout [STAGES];
    logic              sl_ctop [STAGES];

    // A stage may load when it is empty or its content leaves this cycle.
    always_comb begin : ready_chain
        logic nxt;
        nxt  = out_ready;
        load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !vld_q[k] || nxt;
            nxt     = load[k];
        end
    end

    always_comb begin : stage_src
        src_a[0]   = in_a;
        src_b[0]   = (op_e'(in_op) == OP_SUB) ? ~in_b : in_b;
        src_sum[0] = '0;
        src_c[0]   = eff_cin(op_e'(in_op), in_cin);
        src_v[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = pl_q[k-1].carry;
            src_v[k]   = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(.SLICE(SLICE)) u_slice (
            .a     (src_a[k][SLICE-1:0]),
            .b     (src_b[k][SLICE-1:0]),
            .cin   (src_c[k]),
            .sum   (sl_sum[k]),
            .cout  (sl_cout[k]),
            .c_top (sl_ctop[k])
        );
    end

    // Operands shift down so every stage adds their low slice; sum bits
    // shift in from the top so the last stage holds the sum in place.
    always_comb begin : stage_next
        logic [WIDTH-1:0] sum_shift;
        sum_shift = '0;
        vld_d     = vld_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
            pl_d[k]  = pl_q[k];
            if (load[k]) begin
                sum_shift                   = src_sum[k] >> SLICE;
                sum_shift[WIDTH-1 -: SLICE] = sl_sum[k];
                vld_d[k]                    = src_v[k];
                a_d[k]                      = src_a[k] >> SLICE;
                b_d[k]                      = src_b[k] >> SLICE;
                sum_d[k]                    = sum_shift;
                pl_d[k].carry               = sl_cout[k];
                pl_d[k].c_msb               = sl_ctop[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
                pl_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
                pl_q[k]  <= pl_d[k];
            end
        end
    end

    assign in_ready  = rst_n && load[0];
    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = pl_q[STAGES-1].carry;
    assign out_ovf   = pl_q[STAGES-1].carry ^ pl_q[STAGES-1].c_msb;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder in three configurations (1/1, 8/2, 32/4).
module tb_pipe_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit, 4-stage
    logic        a_iv, a_ir, a_cin, a_op, a_ov, a_or, a_cout, a_ovf;
    logic [31:0] a_a, a_b, a_sum;
    // 8-bit, 2-stage
    logic        b_iv, b_ir, b_cin, b_op, b_ov, b_or, b_cout, b_ovf;
    logic [7:0]  b_a, b_b, b_sum;
    // 1-bit, 1-stage
    logic        c_iv, c_ir, c_cin, c_op, c_ov, c_or, c_cout, c_ovf;
    logic        c_a, c_b, c_sum;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_a(a_a), .in_b(a_b),
        .in_cin(a_cin), .in_op(a_op), .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum),
        .out_cout(a_cout), .out_ovf(a_ovf)
    );
    pipe_adder #(.WIDTH(8), .STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_a(b_a), .in_b(b_b),
        .in_cin(b_cin), .in_op(b_op), .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum),
        .out_cout(b_cout), .out_ovf(b_ovf)
    );
    pipe_adder #(.WIDTH(1), .STAGES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_a(c_a), .in_b(c_b),
        .in_cin(c_cin), .in_op(c_op), .out_valid(c_ov), .out_ready(c_or), .out_sum(c_sum),
        .out_cout(c_cout), .out_ovf(c_ovf)
    );

    // Reference: whole-word addition, overflow from operand/result signs.
    function automatic exp_t ref_add(int w, logic [63:0] a, logic [63:0] b, logic cin, logic op);
        exp_t        e;
        logic [63:0] mask, bb;
        logic [64:0] full;
        logic        ci;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bb     = (op ? ~b : b) & mask;
        ci     = op ? ~cin : cin;
        full   = {1'b0, a & mask} + {1'b0, bb} + {64'd0, ci};
        e.sum  = full[63:0] & mask;
        e.cout = full[w];
        e.ovf  = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL rst_a_valid: got %b want 0", a_ov); end
        checks++; if (a_ir !== 1'b0) begin failures++; $display("FAIL rst_a_ready: got %b want 0", a_ir); end
        checks++; if (a_sum !== 32'd0 || a_cout !== 1'b0 || a_ovf !== 1'b0) begin
            failures++; $display("FAIL rst_a_data: got %h/%b/%b want 0/0/0", a_sum, a_cout, a_ovf);
        end
        checks++; if (b_ov !== 1'b0 || b_ir !== 1'b0) begin failures++; $display("FAIL rst_b: got v%b r%b want 0 0", b_ov, b_ir); end
        checks++; if (c_ov !== 1'b0 || c_ir !== 1'b0) begin failures++; $display("FAIL rst_c: got v%b r%b want 0 0", c_ov, c_ir); end
        rst_n = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin failures++; $display("FAIL post_rst_a: got r%b v%b want r1 v0", a_ir, a_ov); end
        checks++; if (b_ir !== 1'b1 || c_ir !== 1'b1) begin failures++; $display("FAIL post_rst_bc_ready: got %b %b want 1 1", b_ir, c_ir); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_adder();
        logic [2:0] v;
        exp_t       e;
        int         lat;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            c_a = v[2]; c_b = v[1]; c_cin = v[0]; c_op = 1'b0; c_iv = 1'b1;
            e.sum  = {63'd0, v[2] ^ v[1] ^ v[0]};
            e.cout = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            e.ovf  = v[0] ^ e.cout;
            qc.push_back(e);
            @(negedge clk);
            checks++; if (c_ir !== 1'b1) begin failures++; $display("FAIL fa_ready[%0d]: got %b want 1", i, c_ir); end
            @(posedge clk); #1;
            c_iv = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!c_ov && lat < 10);
            checks++; if (lat != 1) begin failures++; $display("FAIL fa_latency[%0d]: got %0d want 1", i, lat); end
            if (c_ov) begin
                e = qc.pop_front();
                checks++; if (c_sum !== e.sum[0] || c_cout !== e.cout || c_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL fa_result[%0d]: got s%b c%b o%b want s%b c%b o%b", i, c_sum, c_cout, c_ovf, e.sum[0], e.cout, e.ovf);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_8();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       top [3];
        logic [7:0] ts [3];
        logic       tc [3];
        logic       tv [3];
        exp_t       e;
        int         lat;
        ta = '{8'hFF, 8'h7F, 8'h05}; tb = '{8'h01, 8'h01, 8'h07}; top = '{1'b0, 1'b0, 1'b1};
        ts = '{8'h00, 8'h80, 8'hFE}; tc = '{1'b1, 1'b0, 1'b0}; tv = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            b_a = ta[i]; b_b = tb[i]; b_cin = 1'b0; b_op = top[i]; b_iv = 1'b1;
            e.sum = {56'd0, ts[i]}; e.cout = tc[i]; e.ovf = tv[i];
            qb.push_back(e);
            @(negedge clk);
            checks++; if (b_ir !== 1'b1) begin failures++; $display("FAIL w8_ready[%0d]: got %b want 1", i, b_ir); end
            @(posedge clk); #1;
            b_iv = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!b_ov && lat < 10);
            checks++; if (lat != 2) begin failures++; $display("FAIL w8_latency[%0d]: got %0d want 2", i, lat); end
            if (b_ov) begin
                e = qb.pop_front();
                checks++; if (b_sum !== e.sum[7:0] || b_cout !== e.cout || b_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL w8_result[%0d]: got %h c%b o%b want %h c%b o%b", i, b_sum, b_cout, b_ovf, e.sum[7:0], e.cout, e.ovf);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_32();
        a_or = 1'b1;
        fork
            begin : driver
                int wt;
                for (int i = 0; i < 1000; i++) begin
                    a_a = $urandom; a_b = $urandom;
                    a_cin = 1'($urandom_range(0, 1)); a_op = 1'($urandom_range(0, 1));
                    a_iv = 1'b1;
                    wt = 0;
                    @(negedge clk);
                    while (!a_ir && wt < 200) begin
                        wt++;
                        @(negedge clk);
                    end
                    if (!a_ir) begin
                        checks++; failures++;
                        $display("FAIL rand_accept_timeout: beat %0d not accepted, ready=%b want 1", i, a_ir);
                        break;
                    end
                    qa.push_back(ref_add(32, {32'd0, a_a}, {32'd0, a_b}, a_cin, a_op));
                    @(posedge clk); #1;
                end
                a_iv = 1'b0;
            end
            begin : receiver
                int   got, cyc;
                exp_t e;
                got = 0; cyc = 0;
                while (got < 1000 && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    if (a_ov) begin
                        checks++;
                        if (qa.size() == 0) begin
                            failures++; $display("FAIL rand_extra_beat: got %h want no beat", a_sum);
                        end else begin
                            e = qa[0];
                            if (a_sum !== e.sum[31:0] || a_cout !== e.cout || a_ovf !== e.ovf) begin
                                failures++;
                                $display("FAIL rand_beat[%0d]: got %h c%b o%b want %h c%b o%b", got, a_sum, a_cout, a_ovf, e.sum[31:0], e.cout, e.ovf);
                            end
                            if (a_or) begin
                                void'(qa.pop_front());
                                got++;
                            end
                        end
                    end
                    @(posedge clk); #1;
                    a_or = ($urandom_range(0, 3) != 0);
                end
                checks++; if (got != 1000) begin failures++; $display("FAIL rand_count: got %0d want 1000", got); end
            end
        join
        a_or = 1'b1;
        qa.delete();
    endtask

    task automatic test_fill_stall();
        int   accepts;
        exp_t e;
        a_or = 1'b0;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            a_a = $urandom; a_b = $urandom;
            a_cin = 1'($urandom_range(0, 1)); a_op = 1'($urandom_range(0, 1));
            a_iv = 1'b1;
            @(negedge clk);
            if (!a_ir) break;
            qa.push_back(ref_add(32, {32'd0, a_a}, {32'd0, a_b}, a_cin, a_op));
            accepts++;
            @(posedge clk); #1;
        end
        checks++; if (accepts != 4) begin failures++; $display("FAIL fill_accepts: got %0d want 4", accepts); end
        checks++; if (a_ir !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", a_ir); end
        repeat (2) begin
            e = qa[0];
            checks++; if (a_ov !== 1'b1 || a_sum !== e.sum[31:0] || a_cout !== e.cout || a_ovf !== e.ovf) begin
                failures++;
                $display("FAIL stall_hold: got v%b %h c%b o%b want v1 %h c%b o%b", a_ov, a_sum, a_cout, a_ovf, e.sum[31:0], e.cout, e.ovf);
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        a_or = 1'b1;
        @(negedge clk);
        checks++; if (a_ir !== 1'b1 || a_ov !== 1'b1) begin
            failures++; $display("FAIL same_cycle: got ready=%b valid=%b want 1 1", a_ir, a_ov);
        end
        e = qa.pop_front();
        checks++; if (a_sum !== e.sum[31:0] || a_cout !== e.cout || a_ovf !== e.ovf) begin
            failures++; $display("FAIL drain_first: got %h want %h", a_sum, e.sum[31:0]);
        end
        if (a_ir) qa.push_back(ref_add(32, {32'd0, a_a}, {32'd0, a_b}, a_cin, a_op));
        @(posedge clk); #1;
        a_iv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (qa.size() == 0) break;
            e = qa.pop_front();
            checks++; if (a_ov !== 1'b1 || a_sum !== e.sum[31:0] || a_cout !== e.cout || a_ovf !== e.ovf) begin
                failures++;
                $display("FAIL drain[%0d]: got v%b %h c%b o%b want v1 %h c%b o%b", i, a_ov, a_sum, a_cout, a_ovf, e.sum[31:0], e.cout, e.ovf);
            end
            @(posedge clk); #1;
        end
        checks++; if (a_ov !== 1'b0) begin failures++; $display("FAIL drain_extra: got valid=%b want 0", a_ov); end
        @(posedge clk); #1;
        qa.delete();
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        int   lat, seen;
        a_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_a = $urandom; a_b = $urandom; a_cin = 1'b0; a_op = 1'b0; a_iv = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
        end
        a_iv = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (a_ov !== 1'b0 || a_ir !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl: got valid=%b ready=%b want 0 0", a_ov, a_ir);
        end
        checks++; if (a_sum !== 32'd0) begin failures++; $display("FAIL midrst_sum: got %h want 0", a_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (a_ir !== 1'b1 || a_ov !== 1'b0) begin
            failures++; $display("FAIL midrst_release: got ready=%b valid=%b want 1 0", a_ir, a_ov);
        end
        @(posedge clk); #1;
        a_a = 32'h1234_5678; a_b = 32'h1111_1111; a_cin = 1'b1; a_op = 1'b0; a_iv = 1'b1;
        e.sum = 64'h2345_678A; e.cout = 1'b0; e.ovf = 1'b0;
        qa.push_back(e);
        @(negedge clk);
        @(posedge clk); #1;
        a_iv = 1'b0;
        lat = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_ov) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++; $display("FAIL midrst_extra: got %h want no beat", a_sum);
                end else begin
                    e = qa.pop_front();
                    if (seen == 0) lat = i + 1;
                    if (a_sum !== e.sum[31:0] || a_cout !== e.cout || a_ovf !== e.ovf) begin
                        failures++;
                        $display("FAIL midrst_result: got %h c%b o%b want %h c%b o%b", a_sum, a_cout, a_ovf, e.sum[31:0], e.cout, e.ovf);
                    end
                end
                seen++;
            end
            @(posedge clk); #1;
        end
        checks++; if (seen != 1 || lat != 4) begin
            failures++; $display("FAIL midrst_count: got beats=%0d latency=%0d want 1 4", seen, lat);
        end
        qa.delete();
    endtask

    initial begin
        a_iv = 0; a_a = '0; a_b = '0; a_cin = 0; a_op = 0; a_or = 1;
        b_iv = 0; b_a = '0; b_b = '0; b_cin = 0; b_op = 0; b_or = 1;
        c_iv = 0; c_a = 0;  c_b = 0;  c_cin = 0; c_op = 0; c_or = 1;
        test_reset();
        test_full_adder();
        test_wrap_8();
        test_random_32();
        test_fill_stall();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand and sum width in bits; legal range 1 to 64.
REQ-002 Parameter: STAGES, default 4, number of pipeline stages; legal range 1 to WIDTH; WIDTH % STAGES SHALL equal 0.
REQ-003 Derived constant: SLICE = WIDTH/STAGES, the bits added per stage.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand beat present.
REQ-007 in_ready  out  1  block accepts the beat this cycle.
REQ-008 in_a  in  WIDTH  operand A.
REQ-009 in_b  in  WIDTH  operand B.
REQ-010 in_cin  in  1  carry-in (ADD) or borrow-in (SUB).
REQ-011 in_op  in  1  0 = ADD, 1 = SUB.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_sum  out  WIDTH  result bits.
REQ-015 out_cout  out  1  carry-out of MSB.
REQ-016 out_ovf  out  1  signed overflow.

Function
REQ-017 Transfer rule: an input beat transfers when in_valid && in_ready; an output beat transfers when out_valid && out_ready.
REQ-018 ADD: computes in_a + in_b + in_cin.
REQ-019 SUB: computes in_a + ~in_b + ~in_cin, i.e. a - b - borrow; out_cout = 1 means no borrow.
REQ-020 Stage k (0..STAGES-1) adds operand bits [k*SLICE +: SLICE], using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-021 Each stage carries forward the not-yet-added operand bits, the completed sum bits and the carry.
REQ-022 out_ovf = carry into MSB XOR carry out of MSB; out_cout = carry out of MSB.
REQ-023 Latency: a beat accepted at edge t SHALL present out_valid at edge t+STAGES when no stall occurs.
REQ-024 Throughput: one beat per cycle under continuous out_ready.
REQ-025 Each stage holds a valid bit; stage k loads when it is empty or stage k+1 (or the output, for the last stage) will take its content this cycle.
REQ-026 in_ready = !valid_0 || stage 0 advances this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-027 Stall: while out_valid && !out_ready, out_sum, out_cout and out_ovf SHALL hold stable; the pipeline fills and then drops in_ready after at most STAGES further accepts.
REQ-028 Simultaneous events: when the pipeline is full with out_ready = 1 and in_valid = 1, the block SHALL accept one beat and emit one beat in the same cycle with no bubble.
REQ-029 Ordering: beats SHALL be emitted in acceptance order; none dropped or duplicated.
REQ-030 Wrap-around: the sum is modulo 2^WIDTH, with the excess reported only through out_cout.
REQ-031 Output data bits are don't-care when out_valid = 0.

Reset
REQ-032 Asserting rst_n low SHALL immediately clear all stage valid bits; out_valid = 0 and in_ready = 0 while in reset.
REQ-033 While in reset, out_sum, out_cout and out_ovf SHALL be 0.
REQ-034 Reset mid-operation discards all in-flight beats.
REQ-035 In the first cycle after deassertion, in_ready = 1 and no stale result is emitted.

Structure
REQ-036 Package adder_pkg SHALL hold the op_e enum (OP_ADD = 0, OP_SUB = 1) and a stage-payload struct typedef.
REQ-037 One combinational sub-module, adder_slice (parameter SLICE; inputs a, b, cin; outputs sum, cout, and carry into the top bit), SHALL be instantiated once per stage.
REQ-038 No other sub-modules.

Verification
REQ-039 WIDTH=1, STAGES=1, ADD, all 8 combinations of a, b, cin -> sum and cout match the full-adder truth table (e.g. 1,1,1 -> sum 1, cout 1).
REQ-040 WIDTH=8, STAGES=2, ADD 0xFF + 0x01, cin 0 -> sum 0x00, cout 1, ovf 0, out_valid exactly 2 cycles after accept.
REQ-041 WIDTH=8, ADD 0x7F + 0x01 -> 0x80, ovf 1, cout 0; SUB 0x05 - 0x07, cin 0 -> 0xFE, cout 0, ovf 0.
REQ-042 WIDTH=32, STAGES=4, 1000 random back-to-back beats with out_ready toggled randomly -> every result matches the reference model in order; output held stable during each stall.
REQ-043 Fill the pipeline, hold out_ready = 0 -> in_ready = 0 after 4 accepts; release -> 4 results drain in order, plus a same-cycle accept and emit.
REQ-044 Assert rst_n low with 3 beats in flight -> out_valid = 0 immediately; after release no stale beat appears and the next beat returns the correct result.
